// File: rtl/dmem_bus_responder_pkg.sv
// dmem_bus_responder_pkg: FSM state type, default base address and word-index width rule
package dmem_bus_responder_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
    function automatic int idx_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/dmem_word_array.sv
// dmem_word_array: DEPTH x 32 byte-enabled storage, sync write, registered read
//   clk, we_i/be_i/addr_i/wdata_i write port, re_i loads rdata_o from addr_i
module dmem_word_array
    import dmem_bus_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we_i && be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        if (re_i) rdata_q <= mem_q[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_bus_responder.sv
// dmem_bus_responder: valid/ready data-memory responder with fixed wait states
//   clk, reset (async, active-low)
//   req_valid_i/req_ready_o/req_write_i/req_addr_i/req_wdata_i/req_be_i: request channel
//   rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_err_o: response channel
module dmem_bus_responder
    import dmem_bus_responder_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int AW = idx_w(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          write_q, err_q, rsp_valid_q, rsp_err_q, rsp_ld_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   off, arr_rdata;
    logic          in_err, use_in, commit, c_write, c_err;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_wdata;
    logic [3:0]    c_be;
    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets, caught by the range test.
    assign off    = req_addr_i - BASE_ADDR;
    assign in_err = (|req_addr_i[1:0]) || ({2'b00, off[31:2]} >= 32'(DEPTH));
    // With zero wait states the access commits on the acceptance edge, straight from the inputs.
    assign use_in  = state_q == IDLE;
    assign commit  = use_in ? (req_valid_i && WS == 4'd0) : (state_q == WAIT && cnt_q == 4'd0);
    assign c_write = use_in ? req_write_i : write_q;
    assign c_err   = use_in ? in_err : err_q;
    assign c_idx   = use_in ? off[AW+1:2] : idx_q;
    assign c_wdata = use_in ? req_wdata_i : wdata_q;
    assign c_be    = use_in ? req_be_i : be_q;
    dmem_word_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk     (clk),
        .we_i    (commit && c_write && !c_err),
        .re_i    (commit && !c_write && !c_err),
        .be_i    (c_be),
        .addr_i  (c_idx),
        .wdata_i (c_wdata),
        .rdata_o (arr_rdata)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_ld_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    write_q <= req_write_i;
                    err_q   <= in_err;
                    idx_q   <= off[AW+1:2];
                    wdata_q <= req_wdata_i;
                    be_q    <= req_be_i;
                    state_q <= WS == 4'd0 ? RESP : WAIT;
                    cnt_q   <= WS == 4'd0 ? 4'd0 : WS - 4'd1;
                end
                WAIT: begin
                    state_q <= cnt_q == 4'd0 ? RESP : WAIT;
                    cnt_q   <= cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
                end
                RESP: state_q <= rsp_ready_i ? IDLE : RESP;
                default: state_q <= IDLE;
            endcase
            if (commit) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= c_err;
                rsp_ld_q    <= !c_write && !c_err;
            end else if (state_q == RESP && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_ld_q    <= 1'b0;
            end
        end
    end
    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    // The array read register is not reset, so the output is gated to 0 unless a load response is pending.
    assign rsp_rdata_o = rsp_ld_q ? arr_rdata : '0;
endmodule

// File: doc/dmem_bus_responder.md
DMEM_BUS_RESPONDER -- requirements
Module: dmem_bus_responder

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 256, data-memory size in 32-bit words.
REQ-002 The block SHALL provide parameter WAIT_STATES, default 2, extra cycles inserted before each access completes (range 0..15).
REQ-003 The block SHALL provide parameter BASE_ADDR, default 32'h1001_0000, byte address of word 0.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low, with ports named as follows.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  initiator presents a request.
- req_ready_o  output  1  responder can accept a request.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data.
- req_be_i  input  4  store byte enables; bit n enables byte n.
- rsp_valid_o  output  1  response available.
- rsp_ready_i  input  1  initiator accepts the response.
- rsp_rdata_o  output  32  load data; 0 for stores and errors.
- rsp_err_o  output  1  access faulted.

Function
REQ-005 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-006 In IDLE, req_ready_o SHALL be 1; in all other states it SHALL be 0.
REQ-007 A request SHALL be accepted at a rising edge where req_valid_i and req_ready_o are both 1. At that edge, write, addr, wdata and be SHALL be captured.
REQ-008 On acceptance, the FSM SHALL move to WAIT with the counter loaded to WAIT_STATES-1 when WAIT_STATES>0. It SHALL move directly to RESP when WAIT_STATES=0.
REQ-009 In WAIT, the counter SHALL decrement each cycle. When the counter is 0, the FSM SHALL move to RESP on the next edge.
REQ-010 The memory access SHALL be committed on the edge that enters RESP: a store writes the enabled bytes, and a load registers the addressed word into rsp_rdata_o.
REQ-011 For a request accepted in cycle k, rsp_valid_o SHALL be 1 starting in cycle k+1+WAIT_STATES.
REQ-012 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL hold stable until an edge where rsp_ready_i=1. At that edge, the FSM SHALL return to IDLE.
REQ-013 Back-to-back operation SHALL give a maximum throughput of one request per WAIT_STATES+2 cycles. A request cannot be accepted in the same cycle as the response handshake.
REQ-014 A request SHALL be an error when req_addr_i[1:0]!=0, or when (req_addr_i-BASE_ADDR)>>2 >= DEPTH. Address wrap below BASE_ADDR SHALL also be an error.
REQ-015 An errored access SHALL produce rsp_err_o=1 and rsp_rdata_o=0, and SHALL leave memory unmodified.
REQ-016 A store with req_be_i=4'b0000 SHALL complete without error and without modifying memory.
REQ-017 Inputs SHALL be ignored outside the acceptance edge. A change to req_* while in WAIT or RESP SHALL have no effect.

Reset
REQ-018 While reset=0, the FSM SHALL be IDLE, the counter 0, and the outputs req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 Reset asserted in WAIT SHALL discard the pending access, so no store is committed. Reset asserted in RESP SHALL drop the response.

Structure
REQ-021 The shared package SHALL hold the FSM state enum (IDLE, WAIT, RESP), the default BASE_ADDR, and the word-index computation width rule ($clog2(DEPTH)).
REQ-022 Storage SHALL be one sub-module, dmem_word_array: a synchronous-write, byte-enabled, DEPTH x 32 array with a registered read port. The FSM, counter and address check SHALL live in the top module.

Verification
REQ-023 Load, WAIT_STATES=2: after reset, store 0xDEADBEEF to 0x1001_0004 with be=1111, then load 0x1001_0004 -> rsp_valid_o rises 3 cycles after acceptance; rdata=0xDEADBEEF, err=0.
REQ-024 Byte enables: with word 0 holding 0x11223344, store 0xAABBCCDD with be=0101, then load -> 0x11BB33DD.
REQ-025 Errors: load 0x1001_0002 -> err=1, rdata=0. Store to 0x1001_0400 (DEPTH=256) -> err=1, and a later read of word 0 is unchanged.
REQ-026 Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o stays 1 with stable rdata and req_ready_o=0. Releasing rsp_ready_i -> IDLE on the next edge.
REQ-027 Reset mid-operation: store 0x12345678 to word 3, pulse reset=0 during WAIT, then load word 3 -> old value returned.
REQ-028 Zero wait states: with WAIT_STATES=0, back-to-back loads with rsp_ready_i=1 -> one response every 2 cycles, and rsp_valid_o in cycle k+1.
